// File: rtl/pixel_vector_collector.sv
// Packs VEC_LEN consecutive FIFO pixels into one wide vector and hands it downstream
// over valid/ready. Tracks the vector index within a frame and flags the last one.
module pixel_vector_collector #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned VEC_LEN      = 8,
  parameter int unsigned FRAME_PIXELS = 784,
  parameter int unsigned IDX_WIDTH    = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
  input  logic                          fifo_rd_valid,
  output logic [VEC_LEN*DATA_WIDTH-1:0] out_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_WIDTH-1:0]          out_index,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          err_spurious
);

  localparam int unsigned FillW  = $clog2(VEC_LEN + 1);
  localparam int unsigned NumVec = FRAME_PIXELS / VEC_LEN;

  localparam logic [FillW:0]       VecLenP  = (FillW + 1)'(VEC_LEN);
  localparam logic [FillW-1:0]     LastLane = FillW'(VEC_LEN - 1);
  localparam logic [IDX_WIDTH-1:0] LastIdx  = IDX_WIDTH'(NumVec - 1);

  if ((FRAME_PIXELS % VEC_LEN) != 0) begin : g_frame_chk
    $error("FRAME_PIXELS must be a multiple of VEC_LEN");
  end
  if ((2 ** IDX_WIDTH) < NumVec) begin : g_idx_chk
    $error("IDX_WIDTH too narrow for FRAME_PIXELS/VEC_LEN vectors");
  end

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e                  state_q, state_d;
  logic [FillW-1:0]        fill_q, fill_d;
  logic                    inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   lanes_q [VEC_LEN];
  logic [DATA_WIDTH-1:0]   lanes_d [VEC_LEN];
  logic                    out_valid_q, out_valid_d;
  logic [IDX_WIDTH-1:0]    out_index_q, out_index_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_q, err_d;

  logic                    rd_en;
  logic                    rd_valid_ok;
  logic [FillW:0]          pending;

  for (genvar k = 0; k < VEC_LEN; k++) begin : g_pack
    assign out_vec[k*DATA_WIDTH +: DATA_WIDTH] = lanes_q[k];
  end

  assign out_valid    = out_valid_q;
  assign out_index    = out_index_q;
  assign out_last     = (out_index_q == LastIdx);
  assign frame_done   = frame_done_q;
  assign err_spurious = err_q;
  // Reads must not be requested while the block is held in reset.
  assign fifo_rd_en   = rd_en & rst_n;

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    inflight_d   = inflight_q;
    lanes_d      = lanes_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    rd_en        = 1'b0;

    pending     = {1'b0, fill_q} + {{FillW{1'b0}}, inflight_q};
    rd_valid_ok = fifo_rd_valid && inflight_q && (state_q == StFill);

    // Data with no matching request is dropped and flagged permanently.
    if (fifo_rd_valid && !rd_valid_ok) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StFill: begin
        rd_en = !fifo_empty && (pending < VecLenP);
        if (rd_en) begin
          inflight_d = 1'b1;
        end else if (fifo_rd_valid) begin
          inflight_d = 1'b0;
        end
        if (rd_valid_ok) begin
          for (int unsigned k = 0; k < VEC_LEN; k++) begin
            if (fill_q == FillW'(k)) begin
              lanes_d[k] = fifo_rd_data;
            end
          end
          if (fill_q == LastLane) begin
            fill_d      = '0;
            state_d     = StHold;
            out_valid_d = 1'b1;
          end else begin
            fill_d = fill_q + FillW'(1);
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StFill;
          if (out_last) begin
            out_index_d  = '0;
            frame_done_d = 1'b1;
          end else begin
            out_index_d = out_index_q + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      fill_q       <= '0;
      inflight_q   <= 1'b0;
      lanes_q      <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      inflight_q   <= inflight_d;
      lanes_q      <= lanes_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_pixel_vector_collector.sv
// Bench: small registered FIFO model feeding pixel_vector_collector (VEC_LEN=4, 8-pixel frames).
module tb_pixel_vector_collector;

  localparam int unsigned DW = 16;
  localparam int unsigned VL = 4;
  localparam int unsigned FP = 8;
  localparam int unsigned IW = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fifo_rst_n = 1'b0;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_rd_data;
  logic            fifo_rd_valid;
  logic [VL*DW-1:0] out_vec;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [IW-1:0]   out_index;
  logic            out_last;
  logic            frame_done;
  logic            err_spurious;

  logic            push_valid = 1'b0;
  logic [DW-1:0]   push_data = '0;
  logic            force_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  int rd_viol = 0;

  always #5 clk = ~clk;

  pixel_vector_collector #(
    .DATA_WIDTH  (DW),
    .VEC_LEN     (VL),
    .FRAME_PIXELS(FP),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_valid(fifo_rd_valid),
    .out_vec      (out_vec),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_last     (out_last),
    .frame_done   (frame_done),
    .err_spurious (err_spurious)
  );

  // Sync FIFO model, depth 16: registered empty flag, data valid one cycle after a read.
  logic [DW-1:0] mem [16];
  logic [3:0]    wp, rp;
  logic [4:0]    level;
  logic [DW-1:0] rd_q;
  logic          vld_q;
  logic          push_ok, pop_ok;

  assign push_ok       = push_valid && (level != 5'd16);
  assign pop_ok        = fifo_rd_en && (level != 5'd0);
  assign fifo_empty    = (level == 5'd0);
  assign fifo_rd_valid = vld_q | force_valid;
  assign fifo_rd_data  = force_valid ? 16'hDEAD : rd_q;

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= pop_ok;
      if (pop_ok) begin
        rd_q <= mem[rp];
        rp   <= rp + 4'd1;
      end
      if (push_ok) begin
        mem[wp] <= push_data;
        wp      <= wp + 4'd1;
      end
      level <= level + 5'(push_ok) - 5'(pop_ok);
    end
  end

  // Read request while empty would underflow the FIFO.
  always @(negedge clk) begin
    if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int c = 0; c < 200 && !out_valid; c++) tick();
    check({name, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] pix [4];
    int            gap;
    int            rdly;
    logic [63:0]   exp_vec;
    logic [IW-1:0] exp_idx;
    logic          exp_last;
  } vec_t;

  vec_t tbl [4];
  logic [63:0] held;
  logic [63:0] exp_v;
  int          acc;
  int          fd_cnt;
  int          pi;
  logic        hs;

  initial begin
    tbl[0] = '{'{16'h0001, 16'h0002, 16'h0003, 16'h0004}, 0, 0,
               64'h0004_0003_0002_0001, 7'd0, 1'b0};
    tbl[1] = '{'{16'h0005, 16'h0006, 16'h0007, 16'h0008}, 0, 3,
               64'h0008_0007_0006_0005, 7'd1, 1'b1};
    tbl[2] = '{'{16'h0101, 16'h0102, 16'h0103, 16'h0104}, 4, 0,
               64'h0104_0103_0102_0101, 7'd0, 1'b0};
    tbl[3] = '{'{16'hBEEF, 16'h0000, 16'hFFFF, 16'h1234}, 4, 2,
               64'h1234_FFFF_0000_BEEF, 7'd1, 1'b1};

    // Reset values
    repeat (3) tick();
    check("rst_out_vec", out_vec, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_err", 64'(err_spurious), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    rst_n = 1'b1;
    fifo_rst_n = 1'b1;
    tick();

    // Table-driven vectors: back-to-back and sparse pushes, with optional stall
    for (int e = 0; e < 4; e++) begin
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        push(tbl[e].pix[k]);
        repeat (tbl[e].gap) tick();
      end
      wait_valid($sformatf("tbl%0d", e));
      check($sformatf("tbl%0d_vec", e), out_vec, tbl[e].exp_vec);
      check($sformatf("tbl%0d_idx", e), 64'(out_index), 64'(tbl[e].exp_idx));
      check($sformatf("tbl%0d_last", e), 64'(out_last), 64'(tbl[e].exp_last));
      for (int r = 0; r < tbl[e].rdly; r++) begin
        tick();
        check($sformatf("tbl%0d_hold_vec", e), out_vec, tbl[e].exp_vec);
      end
      handshake();
      check($sformatf("tbl%0d_frame_done", e), 64'(frame_done), 64'(tbl[e].exp_last));
      check($sformatf("tbl%0d_valid_drop", e), 64'(out_valid), 64'd0);
    end

    // Backpressure: 20 stalled cycles with four pixels waiting in the FIFO
    for (int k = 0; k < 8; k++) push(16'(16'h0021 + k));
    wait_valid("stall");
    repeat (2) tick();
    check("stall_vec0", out_vec, 64'h0024_0023_0022_0021);
    check("stall_level0", 64'(level), 64'd4);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("stall_vec", out_vec, 64'h0024_0023_0022_0021);
      check("stall_idx", 64'(out_index), 64'd0);
      check("stall_rd_en", 64'(fifo_rd_en), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    check("stall_level", 64'(level), 64'd4);
    handshake();
    wait_valid("stall2");
    check("stall2_vec", out_vec, 64'h0028_0027_0026_0025);
    check("stall2_idx", 64'(out_index), 64'd1);
    check("stall2_last", 64'(out_last), 64'd1);
    handshake();
    check("stall2_frame_done", 64'(frame_done), 64'd1);
    tick();
    check("frame_done_pulse", 64'(frame_done), 64'd0);

    // Spurious read strobe with nothing in flight
    held = out_vec;
    check("pre_spur_err", 64'(err_spurious), 64'd0);
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    check("spur_err", 64'(err_spurious), 64'd1);
    check("spur_lanes", out_vec, held);
    for (int k = 0; k < 4; k++) push(16'(16'h0031 + k));
    wait_valid("spur");
    check("spur_next_vec", out_vec, 64'h0034_0033_0032_0031);
    check("spur_next_idx", 64'(out_index), 64'd0);
    handshake();
    check("spur_sticky", 64'(err_spurious), 64'd1);

    // Reset mid-vector; one pixel is pushed while reset is held
    push(16'h0041);
    push(16'h0042);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec", out_vec, 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_idx", 64'(out_index), 64'd0);
    check("mid_rst_err", 64'(err_spurious), 64'd0);
    @(posedge clk);
    #1;
    push(16'h00A1);
    check("mid_rst_level", 64'(level), 64'd1);
    check("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
    rst_n = 1'b1;
    for (int k = 1; k < 4; k++) push(16'(16'h00A1 + k));
    wait_valid("post_rst");
    check("post_rst_vec", out_vec, 64'h00A4_00A3_00A2_00A1);
    check("post_rst_idx", 64'(out_index), 64'd0);
    handshake();

    // Three frames with random out_ready and a scoreboard of push order
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    acc = 0;
    fd_cnt = 0;
    pi = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (frame_done) fd_cnt++;
      if (acc == 6) break;
      push_valid = 1'b0;
      if (pi < 24 && level < 5'd14) begin
        push_valid = 1'b1;
        push_data  = 16'(16'h0200 + pi);
        pi++;
      end
      out_ready = 1'($urandom_range(0, 1));
      hs = out_valid && out_ready;
      if (hs) begin
        exp_v = {16'(16'h0200 + 4*acc + 3), 16'(16'h0200 + 4*acc + 2),
                 16'(16'h0200 + 4*acc + 1), 16'(16'h0200 + 4*acc)};
        check($sformatf("stream%0d_vec", acc), out_vec, exp_v);
        check($sformatf("stream%0d_idx", acc), 64'(out_index), 64'(acc % 2));
        check($sformatf("stream%0d_last", acc), 64'(out_last), 64'(acc % 2 == 1));
        acc++;
      end
    end
    push_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_vectors", 64'(acc), 64'd6);
    check("stream_frame_done", 64'(fd_cnt), 64'd3);
    check("no_read_while_empty", 64'(rd_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
